// File: rtl/kcpsm_io_ctrl.sv
// kcpsm_io_ctrl
//   Port-I/O controller between the KCPSM3 soft core and the number-display
//   datapath. Two byte writes (low byte staged, high byte commits) build an
//   atomic DW-bit value. That value is handed downstream over valid/ready.
//   one_second ticks are latched as a sticky status bit that is cleared on read.
//
// Ports
//   CLK1          system clock, posedge
//   arst          synchronous active-high reset
//   port_id       KCPSM3 port address, only [1:0] decoded
//   write_strobe  KCPSM3 output strobe
//   read_strobe   KCPSM3 input strobe
//   out_port      KCPSM3 write data
//   in_port       KCPSM3 read data (combinational on port_id[1:0])
//   tick_in       one_second pulse
//   out_data      committed value to bin2bcd
//   out_valid     out_data valid
//   out_ready     downstream accept
//   Led           mirrors the staged low byte
//
// Build option
//   TICK_COUNT_EN  adds a saturating TCW-bit tick counter, readable on P_LO.
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | nothing staged or pending
// STAGED  | low byte written, not yet committed
// PEND    | value committed, waiting for out_ready
module kcpsm_io_ctrl #(
  parameter int          DW     = 16,
  parameter logic [1:0]  P_STAT = 2'b00,
  parameter logic [1:0]  P_LO   = 2'b01,
  parameter logic [1:0]  P_HI   = 2'b10,
  parameter logic [1:0]  P_CTL  = 2'b11,
  parameter int          TCW    = 8
) (
  input  logic          CLK1,
  input  logic          arst,
  input  logic [7:0]    port_id,
  input  logic          write_strobe,
  input  logic          read_strobe,
  input  logic [7:0]    out_port,
  output logic [7:0]    in_port,
  input  logic          tick_in,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    Led
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STAGED = 2'd1,
    ST_PEND   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      stage_lo_q, stage_lo_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            lo_fresh_q, lo_fresh_d;
  logic            overrun_q, overrun_d;
  logic            tick_pend_q, tick_pend_d;
  logic [7:0]      lo_rd;

  logic wr_lo, wr_hi, wr_ctl, rd_stat, xfer;

  assign wr_lo   = write_strobe && (port_id[1:0] == P_LO);
  assign wr_hi   = write_strobe && (port_id[1:0] == P_HI);
  assign wr_ctl  = write_strobe && (port_id[1:0] == P_CTL);
  assign rd_stat = read_strobe  && (port_id[1:0] == P_STAT);

  // out_valid is exactly "a committed value is waiting"
  assign out_valid = (state_q == ST_PEND);
  assign xfer      = out_valid && out_ready;
  assign out_data  = out_data_q;
  assign Led       = stage_lo_q;

  always_comb begin
    state_d     = state_q;
    stage_lo_d  = stage_lo_q;
    out_data_d  = out_data_q;
    lo_fresh_d  = lo_fresh_q;
    overrun_d   = overrun_q;
    tick_pend_d = tick_pend_q;

    // The outgoing transfer is resolved first so a same-cycle write sees
    // the post-transfer state.
    if (xfer) begin
      state_d    = lo_fresh_q ? ST_STAGED : ST_IDLE;
      lo_fresh_d = 1'b0;
    end

    if (wr_lo) begin
      stage_lo_d = out_port;
      if (state_d == ST_PEND) lo_fresh_d = 1'b1;
      else                    state_d    = ST_STAGED;
    end

    if (wr_hi) begin
      out_data_d = DW'({out_port, stage_lo_q});
      state_d    = ST_PEND;
      lo_fresh_d = 1'b0;
      // Replacing a value that is not leaving this cycle loses it.
      if (out_valid && !out_ready) overrun_d = 1'b1;
    end

    if (wr_ctl) begin
      if (out_port[0]) overrun_d = 1'b0;
      if (out_port[1]) begin
        state_d    = ST_IDLE;
        lo_fresh_d = 1'b0;
      end
    end

    // set beats clear so a tick landing on the clearing read is kept
    if (rd_stat) tick_pend_d = 1'b0;
    if (tick_in) tick_pend_d = 1'b1;
  end

  always_ff @(posedge CLK1) begin
    if (arst) begin
      state_q     <= ST_IDLE;
      stage_lo_q  <= '0;
      out_data_q  <= '0;
      lo_fresh_q  <= 1'b0;
      overrun_q   <= 1'b0;
      tick_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_lo_q  <= stage_lo_d;
      out_data_q  <= out_data_d;
      lo_fresh_q  <= lo_fresh_d;
      overrun_q   <= overrun_d;
      tick_pend_q <= tick_pend_d;
    end
  end

`ifdef TICK_COUNT_EN
  logic [TCW-1:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (rd_stat) tick_cnt_d = '0;
    if (tick_in && (tick_cnt_d != {TCW{1'b1}})) tick_cnt_d = tick_cnt_d + 1'b1;
  end

  always_ff @(posedge CLK1) begin
    if (arst) tick_cnt_q <= '0;
    else      tick_cnt_q <= tick_cnt_d;
  end

  assign lo_rd = 8'(tick_cnt_q);
`else
  logic [31:0] unused_tcw;
  assign unused_tcw = TCW;
  assign lo_rd      = 8'h00;
`endif

  logic unused_port_hi;
  assign unused_port_hi = ^port_id[7:2];

  always_comb begin
    in_port = 8'h00;
    case (port_id[1:0])
      P_STAT:  in_port = {5'b0, overrun_q, out_valid, tick_pend_q};
      P_LO:    in_port = lo_rd;
      default: in_port = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_kcpsm_io_ctrl.sv
module tb_kcpsm_io_ctrl;

  logic        CLK1 = 1'b0;
  logic        arst;
  logic [7:0]  port_id;
  logic        write_strobe;
  logic        read_strobe;
  logic [7:0]  out_port;
  logic [7:0]  in_port;
  logic        tick_in;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  Led;

  kcpsm_io_ctrl dut (
    .CLK1(CLK1), .arst(arst), .port_id(port_id),
    .write_strobe(write_strobe), .read_strobe(read_strobe),
    .out_port(out_port), .in_port(in_port), .tick_in(tick_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .Led(Led)
  );

  always #5 CLK1 = ~CLK1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic [7:0]  led;
  } oexp_t;

  oexp_t       oq[$];
  logic [15:0] xq[$];
  logic [7:0]  rq[$];
  bit          mon_en = 0;

  // Reference model: a committed word is either waiting or not; the low
  // byte register is what the next commit will use.
  logic [7:0]  m_lo;
  logic [15:0] m_data;
  bit          m_valid, m_ovr, m_tick;
  int          m_cnt;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [1:0] p);
    case (p)
      2'd0: return {5'b0, m_ovr, m_valid, m_tick};
`ifdef TICK_COUNT_EN
      2'd1: return 8'(m_cnt);
`endif
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_lo = 0; m_data = 0; m_valid = 0; m_ovr = 0; m_tick = 0; m_cnt = 0;
  endtask

  task automatic cyc(input bit rst, input bit ws, input bit rs, input logic [7:0] pid,
                     input logic [7:0] dat, input bit tk, input bit rdy);
    logic [7:0] old_lo;
    bit rd_stat;
    arst = rst; write_strobe = ws; read_strobe = rs; port_id = pid;
    out_port = dat; tick_in = tk; out_ready = rdy;
    oq.push_back({m_valid, m_data, m_lo});
    if (rs) rq.push_back(model_read(pid[1:0]));
    if (m_valid && rdy) xq.push_back(m_data);
    if (rst) model_reset();
    else begin
      old_lo  = m_lo;
      rd_stat = rs && pid[1:0] == 2'd0;
      if (m_valid && rdy) m_valid = 0;
      if (ws && pid[1:0] == 2'd1) m_lo = dat;
      if (ws && pid[1:0] == 2'd2) begin
        if (m_valid) m_ovr = 1;
        m_data  = {dat, old_lo};
        m_valid = 1;
      end
      if (ws && pid[1:0] == 2'd3) begin
        if (dat[0]) m_ovr = 0;
        if (dat[1]) m_valid = 0;
      end
      if (tk) m_tick = 1;
      else if (rd_stat) m_tick = 0;
      if (rd_stat) m_cnt = tk ? 1 : 0;
      else if (tk && m_cnt < 255) m_cnt++;
    end
    @(posedge CLK1); #1;
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, 0, 8'h00, 8'h00, 0, rdy);
  endtask
  task automatic wr(input logic [7:0] p, input logic [7:0] d, input bit rdy);
    cyc(0, 1, 0, p, d, 0, rdy);
  endtask
  task automatic rd(input logic [7:0] p, input bit tk);
    cyc(0, 0, 1, p, 8'h00, tk, 0);
  endtask

  // monitor: compares whatever the DUT presents against the scoreboard
  always @(negedge CLK1) begin
    if (mon_en) begin
      if (oq.size() == 0) begin
        total++; bad++;
        $display("FAIL out_queue_empty at %0t", $time);
      end else begin
        oexp_t e;
        e = oq.pop_front();
        chk("out_valid", {15'b0, out_valid}, {15'b0, e.v});
        chk("out_data",  out_data, e.d);
        chk("led",       {8'b0, Led}, {8'b0, e.led});
      end
      if (out_valid && out_ready) begin
        if (xq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_transfer data=%h expected none", out_data);
        end else chk("transfer", out_data, xq.pop_front());
      end
      if (read_strobe) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL read_queue_empty got %h", in_port);
        end else chk("in_port", {8'b0, in_port}, {8'b0, rq.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1; write_strobe = 0; read_strobe = 0; port_id = 0;
    out_port = 0; tick_in = 0; out_ready = 0;
    @(posedge CLK1); #1;
    model_reset();
    mon_en = 1;
    idle(0);
    rd(8'h00, 0);

    // basic stage + commit + transfer
    wr(8'h01, 8'h34, 0);
    wr(8'h02, 8'h12, 1);
    idle(1);
    idle(0);

    // overrun and clear
    wr(8'h01, 8'hFF, 0);
    wr(8'h02, 8'h00, 0);
    wr(8'h02, 8'hAB, 0);
    rd(8'h00, 0);
    wr(8'h03, 8'h01, 0);
    rd(8'h00, 0);
    wr(8'h03, 8'h02, 0);
    rd(8'h00, 0);

    // sticky tick, clear on read, tick wins over clear
    cyc(0, 0, 0, 8'h00, 8'h00, 1, 0);
    rd(8'h00, 0);
    rd(8'h00, 0);
    cyc(0, 0, 0, 8'h00, 8'h00, 1, 0);
    rd(8'h00, 1);
    rd(8'h00, 0);
    rd(8'h00, 0);

    // low byte written while pending, then transfer, then commit
    wr(8'h01, 8'h11, 0);
    wr(8'h02, 8'h22, 0);
    wr(8'h01, 8'h55, 0);
    idle(1);
    wr(8'h02, 8'h00, 0);
    idle(1);
    idle(0);

    // commit with ready in same cycle as a pending value: no overrun
    wr(8'h02, 8'h77, 0);
    wr(8'h02, 8'h66, 1);
    rd(8'h00, 0);
    idle(1);

    // reset mid-handshake
    wr(8'h01, 8'h9A, 0);
    wr(8'h02, 8'hBC, 0);
    cyc(1, 0, 0, 8'h00, 8'h00, 0, 0);
    idle(0);
    rd(8'h00, 0);

    // tick counter saturation and clear
    for (int i = 0; i < 300; i++) cyc(0, 0, 0, 8'h00, 8'h00, 1, 0);
    rd(8'h01, 0);
    rd(8'h00, 0);
    rd(8'h01, 0);
    rd(8'hFD, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit rst_r, ws_r, rs_r, tk_r, rdy_r;
      rst_r = ($urandom_range(0, 199) == 0);
      ws_r  = ($urandom_range(0, 2) == 0);
      rs_r  = ($urandom_range(0, 3) == 0);
      tk_r  = ($urandom_range(0, 7) == 0);
      rdy_r = ($urandom_range(0, 2) == 0);
      if (rst_r) begin ws_r = 0; rs_r = 0; rdy_r = 0; end
      cyc(rst_r, ws_r, rs_r, 8'($urandom), 8'($urandom), tk_r, rdy_r);
    end
    idle(1);
    idle(0);

    chk("xfer_queue_drained", 16'(xq.size()), 16'd0);
    chk("read_queue_drained", 16'(rq.size()), 16'd0);
    chk("out_queue_drained",  16'(oq.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
